// File: rtl/gpio_filter_pkg.sv
// Shared defaults and types for the GPIO input synchroniser/glitch filter.
package gpio_filter_pkg;

    localparam int unsigned GPIO_SYNC_STAGES_DEF = 2;
    localparam int unsigned GPIO_FILT_CNT_W_DEF  = 8;

    typedef logic [GPIO_FILT_CNT_W_DEF-1:0] gpio_filt_cnt_t;

endpackage

// File: rtl/gpio_filter_cell.sv
// One pin's stability counter, threshold compare, filtered level and sticky glitch flag.
// Optional glitch flag enabled by macro GPIO_FILTER_GLITCH_EN.
module gpio_filter_cell
    import gpio_filter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = GPIO_FILT_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_sync,
    input  logic                 i_en,
    input  logic [CNT_WIDTH-1:0] i_thr,
    input  logic                 i_glitch_clr,
    output logic                 o_filt,
    output logic                 o_glitch
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_filt;
    logic                 w_diff;
    logic                 w_accept;
    logic                 w_break;

    assign w_diff   = i_sync ^ r_filt;
    // ">=" so a threshold lowered below the running count accepts at once
    assign w_accept = w_diff && (r_cnt >= i_thr);
    assign w_break  = i_en && !w_diff && (r_cnt != '0);

    // Counter stays below i_thr while counting, so it can never wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (!i_en) begin
            r_filt <= i_sync;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_filt <= i_sync;
            r_cnt  <= '0;
        end else if (w_diff) begin
            r_cnt  <= r_cnt + CNT_WIDTH'(1);
        end else begin
            r_cnt  <= '0;
        end
    end

    assign o_filt = r_filt;

`ifdef GPIO_FILTER_GLITCH_EN
    logic r_glitch;

    // Set has priority over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_glitch <= 1'b0;
        end else if (w_break) begin
            r_glitch <= 1'b1;
        end else if (i_glitch_clr) begin
            r_glitch <= 1'b0;
        end
    end

    assign o_glitch = r_glitch;
`else
    logic w_unused_glitch;

    assign w_unused_glitch = i_glitch_clr ^ w_break;
    assign o_glitch        = 1'b0;
`endif

endmodule

// File: rtl/gpio_input_filter.sv
// Per-pin pad synchroniser plus consecutive-cycle glitch filter feeding the GPIO edge detector.
// Sticky glitch_det flags are built only when GPIO_FILTER_GLITCH_EN is defined.
module gpio_input_filter
    import gpio_filter_pkg::*;
#(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = GPIO_SYNC_STAGES_DEF,
    parameter int unsigned CNT_WIDTH   = GPIO_FILT_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     pin_in,
    input  logic [WIDTH-1:0]     filt_en,
    input  logic [CNT_WIDTH-1:0] filt_cycles,
    output logic [WIDTH-1:0]     sync_out,
    output logic [WIDTH-1:0]     filt_out,
    output logic [WIDTH-1:0]     glitch_det,
    input  logic [WIDTH-1:0]     glitch_clr
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync;

    // Multi-flop synchroniser for the asynchronous pad inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= pin_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign sync_out = w_sync;

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        gpio_filter_cell #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .i_sync       (w_sync[g]),
            .i_en         (filt_en[g]),
            .i_thr        (filt_cycles),
            .i_glitch_clr (glitch_clr[g]),
            .o_filt       (filt_out[g]),
            .o_glitch     (glitch_det[g])
        );
    end

endmodule
